// File: rtl/axil_arb_pkg.sv
// axil_arb_pkg: shared FSM encodings and AXI response codes
// for the 2:1 AXI-lite arbiter.
package axil_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_t;

    typedef logic [1:0] resp_t;

    localparam resp_t OKAY   = 2'b00;
    localparam resp_t EXOKAY = 2'b01;
    localparam resp_t SLVERR = 2'b10;
    localparam resp_t DECERR = 2'b11;

    // Pointer breaks ties; a lone requester always wins.
    function automatic logic rr_pick(
        input logic [1:0] req,
        input logic       ptr
    );
        return (req == 2'b11) ? ptr : req[1];
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI_lite: AXI4-lite channel bundle with slave (S) and
// master (M) views.
interface AXI_lite #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic aclk,
    input logic aresetn
);
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport S (
        input  awaddr, awvalid, wdata, wstrb, wvalid,
        input  bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

    modport M (
        output awaddr, awvalid, wdata, wstrb, wvalid,
        output bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_rr_arb.sv
// axil_rr_arb: two-requester round-robin with a registered
// grant, captured while idle and rotated on completion.
module axil_rr_arb
    import axil_arb_pkg::*;
(
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       idle,
    output logic       grant
);

    logic ptr;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ptr   <= 1'b0;
            grant <= 1'b0;
        end else begin
            if (idle && (|req)) begin
                grant <= rr_pick(req, ptr);
            end
            if (advance) begin
                ptr <= ~grant;
            end
        end
    end

endmodule

// File: rtl/axil_arb_2to1.sv
// axil_arb_2to1: shares one AXI-lite slave between two
// requesters; write and read paths arbitrate independently.
module axil_arb_2to1
    import axil_arb_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input logic aclk,
    input logic aresetn,
    AXI_lite.S  s0,
    AXI_lite.S  s1,
    AXI_lite.M  m
);

    wr_state_t wst;
    rd_state_t rst;
    logic      wg;
    logic      rg;
    logic      aw_done;
    logic      w_done;
    logic [1:0] wreq;
    logic [1:0] rreq;
    logic      w_addr;
    logic      w_resp;
    logic      r_addr;
    logic      r_data;
    logic      aw_hs;
    logic      w_hs;
    logic      b_hs;
    logic      ar_hs;
    logic      r_hs;

    logic [AW-1:0]   aw_addr_sel;
    logic [DW-1:0]   w_data_sel;
    logic [DW/8-1:0] w_strb_sel;
    logic [AW-1:0]   ar_addr_sel;

    assign wreq   = {s1.awvalid, s0.awvalid};
    assign rreq   = {s1.arvalid, s0.arvalid};
    assign w_addr = (wst == W_ADDR);
    assign w_resp = (wst == W_RESP);
    assign r_addr = (rst == R_ADDR);
    assign r_data = (rst == R_DATA);

    assign aw_hs = m.awvalid & m.awready;
    assign w_hs  = m.wvalid & m.wready;
    assign b_hs  = m.bvalid & m.bready;
    assign ar_hs = m.arvalid & m.arready;
    assign r_hs  = m.rvalid & m.rready;

    axil_rr_arb u_wr_arb (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     (wreq),
        .advance (w_resp & b_hs),
        .idle    (wst == W_IDLE),
        .grant   (wg)
    );

    axil_rr_arb u_rd_arb (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     (rreq),
        .advance (r_data & r_hs),
        .idle    (rst == R_IDLE),
        .grant   (rg)
    );

    // AW and W may complete in either order; flags mask re-issue.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wst     <= W_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            unique case (wst)
                W_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (|wreq) wst <= W_ADDR;
                end
                W_ADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done | aw_hs) & (w_done | w_hs))
                        wst <= W_RESP;
                end
                W_RESP: begin
                    if (b_hs) begin
                        wst     <= W_IDLE;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                default: wst <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rst <= R_IDLE;
        end else begin
            unique case (rst)
                R_IDLE:  if (|rreq) rst <= R_ADDR;
                R_ADDR:  if (ar_hs) rst <= R_DATA;
                R_DATA:  if (r_hs)  rst <= R_IDLE;
                default: rst <= R_IDLE;
            endcase
        end
    end

    assign aw_addr_sel = wg ? s1.awaddr : s0.awaddr;
    assign w_data_sel  = wg ? s1.wdata  : s0.wdata;
    assign w_strb_sel  = wg ? s1.wstrb  : s0.wstrb;
    assign ar_addr_sel = rg ? s1.araddr : s0.araddr;

    assign m.awaddr  = aw_addr_sel;
    assign m.awvalid = w_addr & ~aw_done
                     & (wg ? s1.awvalid : s0.awvalid);
    assign m.wdata   = w_data_sel;
    assign m.wstrb   = w_strb_sel;
    assign m.wvalid  = w_addr & ~w_done
                     & (wg ? s1.wvalid : s0.wvalid);
    assign m.bready  = w_resp & (wg ? s1.bready : s0.bready);

    assign m.araddr  = ar_addr_sel;
    assign m.arvalid = r_addr & (rg ? s1.arvalid : s0.arvalid);
    assign m.rready  = r_data & (rg ? s1.rready : s0.rready);

    assign s0.awready = w_addr & ~wg & ~aw_done & m.awready;
    assign s1.awready = w_addr &  wg & ~aw_done & m.awready;
    assign s0.wready  = w_addr & ~wg & ~w_done & m.wready;
    assign s1.wready  = w_addr &  wg & ~w_done & m.wready;
    assign s0.bvalid  = w_resp & ~wg & m.bvalid;
    assign s1.bvalid  = w_resp &  wg & m.bvalid;
    assign s0.bresp   = s0.bvalid ? m.bresp : 2'b00;
    assign s1.bresp   = s1.bvalid ? m.bresp : 2'b00;

    assign s0.arready = r_addr & ~rg & m.arready;
    assign s1.arready = r_addr &  rg & m.arready;
    assign s0.rvalid  = r_data & ~rg & m.rvalid;
    assign s1.rvalid  = r_data &  rg & m.rvalid;
    assign s0.rresp   = s0.rvalid ? m.rresp : 2'b00;
    assign s1.rresp   = s1.rvalid ? m.rresp : 2'b00;
    assign s0.rdata   = s0.rvalid ? m.rdata : {DW{1'b0}};
    assign s1.rdata   = s1.rvalid ? m.rdata : {DW{1'b0}};

endmodule

// File: tb/tb_axil_arb_2to1.sv
// tb_axil_arb_2to1: directed requester traffic with queued
// expectations, checked by independent channel monitors.
module tb_axil_arb_2to1;
    import axil_arb_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    AXI_lite #(.AW(32), .DW(32)) s0_if (.aclk(aclk), .aresetn(aresetn));
    AXI_lite #(.AW(32), .DW(32)) s1_if (.aclk(aclk), .aresetn(aresetn));
    AXI_lite #(.AW(32), .DW(32)) m_if  (.aclk(aclk), .aresetn(aresetn));

    axil_arb_2to1 #(.DW(32), .AW(32)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s0      (s0_if),
        .s1      (s1_if),
        .m       (m_if)
    );

    logic [31:0] q_awaddr [2];
    logic [31:0] q_wdata  [2];
    logic [3:0]  q_wstrb  [2];
    logic [31:0] q_araddr [2];
    logic [1:0]  q_awvalid, q_wvalid, q_bready, q_arvalid, q_rready;

    assign s0_if.awaddr  = q_awaddr[0];
    assign s1_if.awaddr  = q_awaddr[1];
    assign s0_if.awvalid = q_awvalid[0];
    assign s1_if.awvalid = q_awvalid[1];
    assign s0_if.wdata   = q_wdata[0];
    assign s1_if.wdata   = q_wdata[1];
    assign s0_if.wstrb   = q_wstrb[0];
    assign s1_if.wstrb   = q_wstrb[1];
    assign s0_if.wvalid  = q_wvalid[0];
    assign s1_if.wvalid  = q_wvalid[1];
    assign s0_if.bready  = q_bready[0];
    assign s1_if.bready  = q_bready[1];
    assign s0_if.araddr  = q_araddr[0];
    assign s1_if.araddr  = q_araddr[1];
    assign s0_if.arvalid = q_arvalid[0];
    assign s1_if.arvalid = q_arvalid[1];
    assign s0_if.rready  = q_rready[0];
    assign s1_if.rready  = q_rready[1];

    logic [1:0]  o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [1:0]  o_bresp [2];
    logic [1:0]  o_rresp [2];
    logic [31:0] o_rdata [2];

    assign o_awready  = {s1_if.awready, s0_if.awready};
    assign o_wready   = {s1_if.wready,  s0_if.wready};
    assign o_bvalid   = {s1_if.bvalid,  s0_if.bvalid};
    assign o_arready  = {s1_if.arready, s0_if.arready};
    assign o_rvalid   = {s1_if.rvalid,  s0_if.rvalid};
    assign o_bresp[0] = s0_if.bresp;
    assign o_bresp[1] = s1_if.bresp;
    assign o_rresp[0] = s0_if.rresp;
    assign o_rresp[1] = s1_if.rresp;
    assign o_rdata[0] = s0_if.rdata;
    assign o_rdata[1] = s1_if.rdata;

    logic        sl_awready, sl_wready, sl_bvalid;
    logic        sl_arready, sl_rvalid;
    logic [1:0]  sl_bresp, sl_rresp;
    logic [31:0] sl_rdata;
    int          wdly = 0;
    bit          bhold = 0;

    assign m_if.awready = sl_awready;
    assign m_if.wready  = sl_wready;
    assign m_if.bvalid  = sl_bvalid;
    assign m_if.bresp   = sl_bresp;
    assign m_if.arready = sl_arready;
    assign m_if.rvalid  = sl_rvalid;
    assign m_if.rresp   = sl_rresp;
    assign m_if.rdata   = sl_rdata;

    logic [31:0] exp_aw [$];
    logic [35:0] exp_w  [$];
    logic [31:0] exp_ar [$];
    logic [1:0]  exp_b0 [$];
    logic [1:0]  exp_b1 [$];
    logic [33:0] exp_r0 [$];
    logic [33:0] exp_r1 [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got traffic %0h required none", nm, act);
    endtask

    function automatic logic [63:0] outs();
        return {41'd0, m_if.awvalid, m_if.wvalid, m_if.bready,
                m_if.arvalid, m_if.rready, o_awready, o_wready,
                o_bvalid, o_arready, o_rvalid, o_bresp[0],
                o_bresp[1], o_rresp[0], o_rresp[1]};
    endfunction

    // Zero-wait slave with optional W delay and B hold.
    initial begin : slave
        bit f_aw, f_w, f_b, f_ar, f_r, rst;
        bit aw_got, w_got;
        int wcnt;
        logic [31:0] wa, ra;
        sl_awready = 1'b1; sl_wready = 1'b1; sl_bvalid = 1'b0;
        sl_bresp = 2'b00; sl_arready = 1'b1; sl_rvalid = 1'b0;
        sl_rdata = '0; sl_rresp = 2'b00;
        aw_got = 0; w_got = 0; wcnt = 0; wa = '0; ra = '0;
        forever begin
            @(negedge aclk);
            rst  = !aresetn;
            f_aw = m_if.awvalid & sl_awready;
            f_w  = m_if.wvalid & sl_wready;
            f_b  = sl_bvalid & m_if.bready;
            f_ar = m_if.arvalid & sl_arready;
            f_r  = sl_rvalid & m_if.rready;
            if (f_aw) wa = m_if.awaddr;
            if (f_ar) ra = m_if.araddr;
            @(posedge aclk);
            #1;
            if (rst) begin
                aw_got = 0; w_got = 0; wcnt = 0;
                sl_bvalid = 1'b0; sl_rvalid = 1'b0;
                sl_wready = (wdly == 0);
            end else begin
                if (f_aw) aw_got = 1;
                if (f_w)  w_got = 1;
                if (aw_got && !w_got) wcnt++;
                sl_wready = (wdly == 0) ? 1'b1
                          : (aw_got && !w_got && wcnt >= wdly);
                if (f_b) begin
                    sl_bvalid = 1'b0; aw_got = 0; w_got = 0; wcnt = 0;
                end else if (aw_got && w_got && !sl_bvalid && !bhold) begin
                    sl_bvalid = 1'b1;
                    sl_bresp = (wa == 32'h40) ? DECERR : OKAY;
                end
                if (f_r) sl_rvalid = 1'b0;
                if (f_ar) begin
                    sl_rvalid = 1'b1;
                    sl_rdata = (ra == 32'h8) ? 32'h12345678
                             : (ra ^ 32'hA5A5_0000);
                    sl_rresp = (ra == 32'h20) ? SLVERR : OKAY;
                end
            end
        end
    end

    initial begin : mon_m
        bit aw_seen, w_seen;
        logic [63:0] e;
        aw_seen = 0; w_seen = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                aw_seen = 0; w_seen = 0;
            end else begin
                if (aw_seen) chk("m_awvalid_masked", m_if.awvalid, 0);
                if (w_seen)  chk("m_wvalid_masked", m_if.wvalid, 0);
                if (m_if.awvalid && sl_awready) begin
                    if (exp_aw.size() == 0) unexp("m_aw", m_if.awaddr);
                    else begin
                        e = exp_aw.pop_front();
                        chk("m_awaddr", m_if.awaddr, e);
                    end
                    aw_seen = 1;
                end
                if (m_if.wvalid && sl_wready) begin
                    if (exp_w.size() == 0) unexp("m_w", m_if.wdata);
                    else begin
                        e = exp_w.pop_front();
                        chk("m_wstrb_wdata", {m_if.wstrb, m_if.wdata}, e);
                    end
                    w_seen = 1;
                end
                if (m_if.bvalid && m_if.bready) begin
                    aw_seen = 0; w_seen = 0;
                end
                if (m_if.arvalid && sl_arready) begin
                    if (exp_ar.size() == 0) unexp("m_ar", m_if.araddr);
                    else begin
                        e = exp_ar.pop_front();
                        chk("m_araddr", m_if.araddr, e);
                    end
                end
            end
        end
    end

    initial begin : mon_s
        logic [63:0] e;
        forever begin
            @(negedge aclk);
            for (int s = 0; s < 2; s++) begin
                if (o_bvalid[s]) begin
                    if (!q_bready[s]) unexp($sformatf("s%0d_b_noready", s), o_bresp[s]);
                    else if (s == 0 && exp_b0.size() != 0) begin
                        e = exp_b0.pop_front();
                        chk("s0_bresp", o_bresp[0], e);
                    end else if (s == 1 && exp_b1.size() != 0) begin
                        e = exp_b1.pop_front();
                        chk("s1_bresp", o_bresp[1], e);
                    end else unexp($sformatf("s%0d_b", s), o_bresp[s]);
                end
                if (o_rvalid[s]) begin
                    if (!q_rready[s]) unexp($sformatf("s%0d_r_noready", s), o_rdata[s]);
                    else if (s == 0 && exp_r0.size() != 0) begin
                        e = exp_r0.pop_front();
                        chk("s0_rresp_rdata", {o_rresp[0], o_rdata[0]}, e);
                    end else if (s == 1 && exp_r1.size() != 0) begin
                        e = exp_r1.pop_front();
                        chk("s1_rresp_rdata", {o_rresp[1], o_rdata[1]}, e);
                    end else unexp($sformatf("s%0d_r", s), o_rdata[s]);
                end
                if (o_bvalid[1-s])
                    chk($sformatf("s%0d_wr_quiet", s),
                        {o_bvalid[s], o_bresp[s], o_awready[s], o_wready[s]}, 0);
                if (o_rvalid[1-s])
                    chk($sformatf("s%0d_rd_quiet", s),
                        {o_rvalid[s], o_rresp[s], o_rdata[s], o_arready[s]}, 0);
            end
        end
    end

    task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
        exp_aw.push_back(a);
        exp_w.push_back({4'hF, d});
    endtask

    task automatic wr(input int s, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] r);
        bit ah, wh, bh, done;
        int n;
        ah = 0; wh = 0; bh = 0; done = 0; n = 0;
        if (s == 0) exp_b0.push_back(r); else exp_b1.push_back(r);
        q_awaddr[s] = a; q_wdata[s] = d; q_wstrb[s] = 4'hF;
        q_awvalid[s] = 1'b1; q_wvalid[s] = 1'b1; q_bready[s] = 1'b1;
        while (!done && n < 60) begin
            @(negedge aclk);
            ah = q_awvalid[s] & o_awready[s];
            wh = q_wvalid[s] & o_wready[s];
            bh = o_bvalid[s] & q_bready[s];
            @(posedge aclk);
            #1;
            n++;
            if (ah) q_awvalid[s] = 1'b0;
            if (wh) q_wvalid[s] = 1'b0;
            if (bh) begin q_bready[s] = 1'b0; done = 1; end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wr_done s%0d addr %0h: got no B handshake, required one", s, a);
        end
    endtask

    task automatic rd(input int s, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] r);
        bit ah, rh, done;
        int n;
        ah = 0; rh = 0; done = 0; n = 0;
        if (s == 0) exp_r0.push_back({r, d}); else exp_r1.push_back({r, d});
        q_araddr[s] = a; q_arvalid[s] = 1'b1; q_rready[s] = 1'b1;
        while (!done && n < 60) begin
            @(negedge aclk);
            ah = q_arvalid[s] & o_arready[s];
            rh = o_rvalid[s] & q_rready[s];
            @(posedge aclk);
            #1;
            n++;
            if (ah) q_arvalid[s] = 1'b0;
            if (rh) begin q_rready[s] = 1'b0; done = 1; end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rd_done s%0d addr %0h: got no R handshake, required one", s, a);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit wr_fin, ah, wh;
        int n;
        for (int i = 0; i < 2; i++) begin
            q_awaddr[i] = '0; q_wdata[i] = '0; q_wstrb[i] = '0;
            q_araddr[i] = '0;
        end
        q_awvalid = '0; q_wvalid = '0; q_bready = '0;
        q_arvalid = '0; q_rready = '0;

        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_outputs", outs(), 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Lone s0 write: AW reaches m one cycle after the request.
        exp_write(32'h10, 32'hDEADBEEF);
        fork
            wr(0, 32'h10, 32'hDEADBEEF, OKAY);
            begin
                @(negedge aclk);
                chk("aw_cycle_n", m_if.awvalid, 0);
                @(negedge aclk);
                chk("aw_cycle_n1", {m_if.awvalid, m_if.awaddr}, {1'b1, 32'h10});
            end
        join

        // Lone s1 write returns the write pointer to s0.
        exp_write(32'h14, 32'h0000_1414);
        wr(1, 32'h14, 32'h0000_1414, OKAY);

        // Same-cycle writes: s0 first, then s1.
        exp_write(32'h0, 32'hA0A0_0000);
        exp_write(32'h4, 32'hB1B1_0004);
        fork
            wr(0, 32'h0, 32'hA0A0_0000, OKAY);
            wr(1, 32'h4, 32'hB1B1_0004, OKAY);
        join

        // Slave delays W by 5 cycles after AW.
        wdly = 5;
        @(posedge aclk);
        #1;
        exp_write(32'h30, 32'h3030_3030);
        wr(1, 32'h30, 32'h3030_3030, OKAY);

        // s1 read overtakes a slow s0 write.
        exp_write(32'h18, 32'h0BAD_CAFE);
        exp_ar.push_back(32'h8);
        wr_fin = 0;
        fork
            begin
                wr(0, 32'h18, 32'h0BAD_CAFE, OKAY);
                wr_fin = 1;
            end
            begin
                rd(1, 32'h8, 32'h12345678, OKAY);
                chk("rd_before_wr", wr_fin, 0);
            end
        join
        wdly = 0;
        @(posedge aclk);
        #1;

        // DECERR passes through unmodified.
        exp_write(32'h40, 32'h1111_2222);
        wr(0, 32'h40, 32'h1111_2222, DECERR);

        // SLVERR read to s0, then the pointer favours s1.
        exp_ar.push_back(32'h20);
        rd(0, 32'h20, 32'hA5A5_0020, SLVERR);
        exp_ar.push_back(32'h28);
        exp_ar.push_back(32'h24);
        fork
            rd(0, 32'h24, 32'hA5A5_0024, OKAY);
            rd(1, 32'h28, 32'hA5A5_0028, OKAY);
        join

        // Reset while s1 write waits in W_RESP.
        bhold = 1;
        exp_write(32'h60, 32'hCAFE_F00D);
        q_awaddr[1] = 32'h60; q_wdata[1] = 32'hCAFE_F00D; q_wstrb[1] = 4'hF;
        q_awvalid[1] = 1'b1; q_wvalid[1] = 1'b1; q_bready[1] = 1'b1;
        n = 0;
        while ((q_awvalid[1] || q_wvalid[1]) && n < 20) begin
            @(negedge aclk);
            ah = q_awvalid[1] & o_awready[1];
            wh = q_wvalid[1] & o_wready[1];
            @(posedge aclk);
            #1;
            n++;
            if (ah) q_awvalid[1] = 1'b0;
            if (wh) q_wvalid[1] = 1'b0;
        end
        chk("abort_aw_w_done", {q_awvalid[1], q_wvalid[1]}, 0);
        q_awvalid[1] = 1'b0; q_wvalid[1] = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(negedge aclk);
        chk("wresp_bready", m_if.bready, 1);
        q_bready[1] = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("reset_mid_outputs", outs(), 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        bhold = 0;
        @(posedge aclk);
        #1;

        exp_write(32'h50, 32'h5050_5050);
        exp_write(32'h54, 32'h5454_5454);
        fork
            wr(0, 32'h50, 32'h5050_5050, OKAY);
            wr(1, 32'h54, 32'h5454_5454, OKAY);
        join

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("left_aw", exp_aw.size(), 0);
        chk("left_w",  exp_w.size(), 0);
        chk("left_ar", exp_ar.size(), 0);
        chk("left_b",  exp_b0.size() + exp_b1.size(), 0);
        chk("left_r",  exp_r0.size() + exp_r1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_arb_2to1.md
AXIL_ARB_2TO1 -- requirements
Module: axil_arb_2to1

Interface
REQ-001 Parameters: DW, default 32, data width; AW, default 32, address width.
REQ-002 aclk  input  1  single clock; all logic on posedge aclk.
REQ-003 aresetn  input  1  reset, synchronous, active-low.
REQ-004 s0  AXI_lite.S modport  DW/AW  upstream requester 0; its aclk/aresetn are tied to the top-level aclk/aresetn.
REQ-005 s1  AXI_lite.S modport  DW/AW  upstream requester 1; its aclk/aresetn are tied to the top-level aclk/aresetn.
REQ-006 m  AXI_lite.M modport  DW/AW  downstream shared slave port.

Function
REQ-007 Write and read paths SHALL be arbitrated independently, each with its own FSM and round-robin pointer.
REQ-008 Write FSM states: W_IDLE, W_ADDR, W_RESP.
- W_IDLE -> W_ADDR when either sX.awvalid=1.
- W_ADDR -> W_RESP once both the AW and W handshakes to m have occurred, in either order or in the same cycle.
- W_RESP -> W_IDLE on m.bvalid & bready.
REQ-009 Read FSM states: R_IDLE, R_ADDR, R_DATA.
- R_IDLE -> R_ADDR when either sX.arvalid=1.
- R_ADDR -> R_DATA on m.arvalid & arready.
- R_DATA -> R_IDLE on m.rvalid & rready.
REQ-010 Grant SHALL be registered on the IDLE exit.
- Request first seen in cycle N: m.awvalid/m.arvalid asserted at N+1.
- One cycle of arbitration latency; no combinational path from sX.*valid to the grant.
REQ-011 Simultaneous requests: the grant SHALL go to the requester favoured by the pointer; the pointer favours s0 out of reset.
REQ-012 The pointer SHALL move to favour the other requester only on transaction completion (B or R handshake).
REQ-013 Grant SHALL be held from IDLE exit until completion; exactly one transaction is outstanding per path.
REQ-014 While granted, the granted requester's channel signals SHALL be passed combinationally to/from m.
- Write path: aw*, w*, b*.
- Read path: ar*, r*.
- rresp/bresp/rdata are passed unmodified, including SLVERR/DECERR.
REQ-015 The non-granted requester SHALL see awready, wready, arready, bvalid and rvalid all 0; bresp, rresp and rdata driven 0.
REQ-016 m.awvalid SHALL be masked to 0 after the AW handshake; m.wvalid SHALL be masked to 0 after the W handshake within the same transaction.
- Needs aw_done and w_done flags, cleared on W_IDLE entry.
REQ-017 In IDLE, m.*valid SHALL be 0 and m.bready/m.rready SHALL be 0.
REQ-018 A requester dropping valid before its handshake is a protocol violation; no recovery is required beyond reset.
REQ-019 Back-to-back operation:
- A new grant may occur in the cycle after completion.
- Sustained alternating requests SHALL reach one write per 3 cycles minimum when the slave is zero-wait.

Reset
REQ-020 On aresetn=0 at posedge aclk, registers SHALL take these values:
- Both FSMs to IDLE.
- Pointers favour s0.
- aw_done and w_done cleared.
- All m.*valid, m.*ready and all sX ready/valid outputs 0 in the following cycle.
REQ-021 Reset mid-transaction SHALL abandon the transaction with no response to the requester; the downstream slave is reset by the same aresetn.

Structure
REQ-022 Package axil_arb_pkg SHALL hold:
- The wr_state_t and rd_state_t enums.
- The AXI resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
REQ-023 Sub-module axil_rr_arb SHALL provide the 2-requester round-robin with inputs req[1:0], advance and idle, and output grant (1 bit registered); it is instantiated once per path.
REQ-024 The channel muxes SHALL be combinational on the registered grant; no skid buffers.

Verification
REQ-025 s0 write data=0xDEADBEEF, addr=0x10, strb=0xF alone -> m.awaddr=0x10 at N+1; s0 gets bresp=OKAY; s1 sees no b traffic.
REQ-026 s0 and s1 writes issued in the same cycle (addr 0x0 and 0x4) -> s0 is served first, then s1; m sees exactly two AW handshakes in order 0x0, 0x4.
REQ-027 Slave delays wready 5 cycles after awready -> m.awvalid is low during the delay and exactly one W handshake occurs; bvalid is returned to the correct requester.
REQ-028 s1 read addr=0x8 while s0 write is outstanding -> read completes independently; rdata=0x12345678 reaches s1 only.
REQ-029 Slave returns rresp=SLVERR to s0 read -> s0 sees rresp=2'b10; pointer then favours s1.
REQ-030 aresetn=0 during W_RESP -> next cycle all outputs are 0 and the FSM is in W_IDLE; the next request is granted to s0.
